// File: rtl/led_blink_driver.sv
// led_blink_driver: turns one-cycle event pulses into visible LED blinks.
// Events arriving mid-blink are queued (up to 15) and replayed back-to-back.
module led_blink_driver #(
  parameter int ON_TIME        = 7200000,
  parameter int OFF_TIME       = 7200000,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic       Fg_CLK,
  input  logic       RESETn,
  input  logic       IntEvent,
  output logic       ExtLED,
  output logic       Busy,
  output logic [3:0] Pending,
  output logic       Overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  localparam logic [25:0] ON_LAST  = 26'(ON_TIME - 1);
  localparam logic [25:0] OFF_LAST = 26'(OFF_TIME - 1);

  localparam logic LED_LIT  = (LED_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic LED_DARK = ~LED_LIT;

  logic [1:0]  state;
  logic [25:0] cnt;

  logic has_pend;
  logic on_done;
  logic off_done;
  logic direct;
  logic dec;
  logic inc;
  logic start;

  // Decide this edge's queue traffic and whether a blink begins.
  always_comb begin
    has_pend = (Pending != 4'd0);
    on_done  = (state == ST_ON) && (cnt == ON_LAST);
    off_done = (state == ST_OFF) && (cnt == OFF_LAST);
    direct   = (state == ST_IDLE) && !has_pend && IntEvent;
    dec      = has_pend && ((state == ST_IDLE) || off_done);
    inc      = IntEvent && !direct;
    start    = direct || dec;
  end

  // Blink sequencer, event queue counter and registered outputs.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= ST_IDLE;
      cnt      <= 26'd0;
      ExtLED   <= LED_DARK;
      Busy     <= 1'b0;
      Pending  <= 4'd0;
      Overflow <= 1'b0;
    end else begin
      Overflow <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_ON;
            cnt    <= 26'd0;
            ExtLED <= LED_LIT;
            Busy   <= 1'b1;
          end
        end
        ST_ON: begin
          if (on_done) begin
            state  <= ST_OFF;
            cnt    <= 26'd0;
            ExtLED <= LED_DARK;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        ST_OFF: begin
          if (off_done) begin
            cnt <= 26'd0;
            if (start) begin
              state  <= ST_ON;
              ExtLED <= LED_LIT;
            end else begin
              state <= ST_IDLE;
              Busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= 26'd0;
          ExtLED <= LED_DARK;
          Busy   <= 1'b0;
        end
      endcase

      if (inc && !dec) begin
        if (Pending == 4'd15) begin
          Overflow <= 1'b1;
        end else begin
          Pending <= Pending + 4'd1;
        end
      end else if (dec && !inc) begin
        Pending <= Pending - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_blink_driver.sv
// tb_led_blink_driver: scoreboard bench for led_blink_driver.
// Reference model schedules blink start times; monitor compares each cycle.
module tb_led_blink_driver;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;

  logic       clk;
  logic       rst_n;
  logic       ev;
  logic       led, busy, ovf;
  logic [3:0] pend;
  logic       led2, busy2, ovf2;
  logic [3:0] pend2;

  led_blink_driver #(
    .ON_TIME(ON), .OFF_TIME(OFF), .LED_ACTIVE_LOW(0)
  ) u_dut (
    .Fg_CLK(clk), .RESETn(rst_n), .IntEvent(ev),
    .ExtLED(led), .Busy(busy), .Pending(pend), .Overflow(ovf)
  );

  led_blink_driver #(
    .ON_TIME(ON), .OFF_TIME(OFF), .LED_ACTIVE_LOW(1)
  ) u_dut_al (
    .Fg_CLK(clk), .RESETn(rst_n), .IntEvent(ev),
    .ExtLED(led2), .Busy(busy2), .Pending(pend2), .Overflow(ovf2)
  );

  typedef struct {
    int         c;
    logic       led;
    logic       busy;
    logic [3:0] pend;
    logic       ovf;
  } exp_t;

  exp_t sbq[$];
  int   starts[$];
  int   last_s;
  int   c;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int cy,
                     input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cy, act, exp);
    end
  endtask

  // Model: every accepted event owns a blink window [s, s+P-1].
  task automatic model(input int cy, input logic e, output exp_t x);
    int  pb;
    bit  dq;
    int  ns;
    int  np;
    x.c   = cy;
    x.ovf = 1'b0;
    while (starts.size() > 0 && starts[0] + P - 1 < cy)
      void'(starts.pop_front());
    if (e) begin
      pb = 0;
      dq = 0;
      foreach (starts[i]) begin
        if (starts[i] >= cy) pb++;
        if (starts[i] == cy) dq = 1;
      end
      if (pb == 0 && cy > last_s + P) begin
        starts.push_back(cy);
        last_s = cy;
      end else if (pb == 15 && !dq) begin
        x.ovf = 1'b1;
      end else begin
        ns = (last_s + P > cy + 1) ? last_s + P : cy + 1;
        starts.push_back(ns);
        last_s = ns;
      end
    end
    x.led  = 1'b0;
    x.busy = 1'b0;
    np     = 0;
    foreach (starts[i]) begin
      if (starts[i] <= cy && cy <= starts[i] + ON - 1) x.led = 1'b1;
      if (starts[i] <= cy && cy <= starts[i] + P - 1) x.busy = 1'b1;
      if (starts[i] > cy) np++;
    end
    x.pend = 4'(np);
  endtask

  // Drive one cycle from a negedge and queue its expected response.
  task automatic step(input logic e);
    exp_t x;
    ev = e;
    model(c, e, x);
    sbq.push_back(x);
    c++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // Monitor: compare registered outputs just after each edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk("led",      x.c, {3'd0, led},  {3'd0, x.led});
      chk("busy",     x.c, {3'd0, busy}, {3'd0, x.busy});
      chk("pending",  x.c, pend,         x.pend);
      chk("overflow", x.c, {3'd0, ovf},  {3'd0, x.ovf});
      chk("led_al",   x.c, {3'd0, led2}, {3'd0, ~x.led});
    end
  end

  initial begin
    total  = 0;
    bad    = 0;
    c      = 0;
    last_s = -100;
    ev     = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led_al", -1, {3'd0, led2}, 4'd1);
    rst_n = 1'b1;

    step(1'b1);
    idle(8);

    step(1'b1); step(1'b1); step(1'b1);
    idle(14);

    step(1'b1); step(1'b1); step(1'b1);
    step(1'b0); step(1'b0); step(1'b1);
    idle(25);

    for (int i = 0; i < 17; i++) step(1'b1);
    idle(16 * P + 5);

    step(1'b1); step(1'b1); step(1'b1); step(1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_led",   c, {3'd0, led},  4'd0);
    chk("rst_busy",  c, {3'd0, busy}, 4'd0);
    chk("rst_pend",  c, pend,         4'd0);
    chk("rst_ovf",   c, {3'd0, ovf},  4'd0);
    chk("rst_led2",  c, {3'd0, led2}, 4'd1);
    starts.delete();
    c      = 0;
    last_s = -100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int seg = 0; seg < 12; seg++) begin
      int prob;
      prob = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 30 : 85);
      for (int i = 0; i < 200; i++)
        step(($urandom_range(0, 99) < prob) ? 1'b1 : 1'b0);
    end
    idle(16 * P + 10);
    @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
